// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - channel count, select/one-hot types shared by the 1:16 mux and demux
package demux_pkg;
    localparam int N_CH  = 16;
    localparam int SEL_W = 4;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [N_CH-1:0]  onehot_t;

    function automatic onehot_t to_onehot(input sel_t idx);
        return onehot_t'(1) << idx;
    endfunction
endpackage

// File: rtl/rr_prio_encoder16.sv
// rtl/rr_prio_encoder16.sv - 16-way rotating/fixed priority encoder, purely combinational
module rr_prio_encoder16
    import demux_pkg::*;
(
    input  onehot_t req,
    input  sel_t    ptr,
    input  logic    fixed_mode,
    output onehot_t gnt_onehot,
    output sel_t    gnt_idx,
    output logic    any
);
    sel_t start;
    sel_t cand;

    always_comb begin
        start   = fixed_mode ? '0 : ptr;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        // Search upward from start; the 4-bit add wraps 15 -> 0 naturally.
        for (int i = 0; i < N_CH; i++) begin
            cand = start + sel_t'(i);
            if (!any && req[cand]) begin
                gnt_idx = cand;
                any     = 1'b1;
            end
        end
        gnt_onehot = any ? to_onehot(gnt_idx) : '0;
    end
endmodule

// File: rtl/mux_16to1_rr.sv
// rtl/mux_16to1_rr.sv - 16:1 valid/ready collector with round-robin or fixed arbitration
module mux_16to1_rr
    import demux_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PRIO_MODE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        in_valid,
    input  logic [N_CH*DATA_W-1:0] in_data,
    output logic [N_CH-1:0]        in_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_sel,
    input  logic                   out_ready
);
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    sel_t              out_sel_q, out_sel_d;
    sel_t              ptr_q, ptr_d;

    onehot_t gnt_onehot;
    sel_t    gnt_idx;
    logic    gnt_any;
    logic    load;

    rr_prio_encoder16 u_enc (
        .req        (in_valid),
        .ptr        (ptr_q),
        .fixed_mode (PRIO_MODE != 0),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    assign load = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        in_ready    = '0;
        // No accept during reset so a source never believes a dropped beat was taken.
        if (load && rst_n) begin
            if (gnt_any) begin
                in_ready    = gnt_onehot;
                out_valid_d = 1'b1;
                out_data_d  = in_data[gnt_idx*DATA_W +: DATA_W];
                out_sel_d   = gnt_idx;
                ptr_d       = gnt_idx + sel_t'(1);
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux_16to1_rr.sv
// tb/tb_mux_16to1_rr.sv - directed checks of round-robin and fixed-priority collectors
module tb_mux_16to1_rr;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  in_valid;
    logic [127:0] in_data;
    logic         out_ready;

    logic [15:0] rr_in_ready, fp_in_ready;
    logic        rr_out_valid, fp_out_valid;
    logic [7:0]  rr_out_data, fp_out_data;
    logic [3:0]  rr_out_sel, fp_out_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_16to1_rr #(.DATA_W(8), .PRIO_MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_data(rr_out_data),
        .out_sel(rr_out_sel), .out_ready(out_ready)
    );

    mux_16to1_rr #(.DATA_W(8), .PRIO_MODE(1)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_data(fp_out_data),
        .out_sel(fp_out_sel), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One granted RR beat: check the accept before the edge, the output after it.
    task automatic rr_beat(input string tag, input int ch, input logic [7:0] data);
        #1;
        chk({tag, "_rdy"}, 32'(rr_in_ready), 32'(16'h1 << ch));
        tick();
        chk({tag, "_vld"}, 32'(rr_out_valid), 32'd1);
        chk({tag, "_sel"}, 32'(rr_out_sel), 32'(ch));
        chk({tag, "_dat"}, 32'(rr_out_data), 32'(data));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 16'hFFFF;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) in_data[i*8 +: 8] = 8'(i + 16);

        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_vld", 32'(rr_out_valid), 32'd0);
            chk("rst_sel", 32'(rr_out_sel), 32'd0);
            chk("rst_dat", 32'(rr_out_data), 32'd0);
            chk("rst_rdy", 32'(rr_in_ready), 32'd0);
        end

        rst_n = 1'b1;
        rr_beat("first", 0, 8'h10);
        for (int k = 1; k <= 16; k++) rr_beat("sweep", k % 16, 8'(16 + (k % 16)));

        in_valid = 16'h2000;
        rr_beat("pre14", 13, 8'h1D);
        in_valid = 16'h8003;
        rr_beat("wrap15", 15, 8'h1F);
        rr_beat("wrap0", 0, 8'h10);
        rr_beat("wrap1", 1, 8'h11);
        rr_beat("wrap15b", 15, 8'h1F);

        in_data[5*8 +: 8] = 8'hA5;
        in_valid = 16'h0020;
        rr_beat("bp_load", 5, 8'hA5);
        in_valid  = 16'h0040;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_rdy", 32'(rr_in_ready), 32'd0);
            tick();
            chk("bp_vld", 32'(rr_out_valid), 32'd1);
            chk("bp_sel", 32'(rr_out_sel), 32'd5);
            chk("bp_dat", 32'(rr_out_data), 32'hA5);
        end
        out_ready = 1'b1;
        rr_beat("bp_nobubble", 6, 8'h16);

        in_valid = 16'h0110;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fp_rdy", 32'(fp_in_ready), 32'h0010);
            tick();
            chk("fp_sel", 32'(fp_out_sel), 32'd4);
            chk("fp_dat", 32'(fp_out_data), 32'h14);
            chk("rr_alt", 32'(rr_out_sel), (k % 2 == 0) ? 32'd8 : 32'd4);
        end
        in_valid = 16'h0100;
        #1;
        chk("fp_rdy8", 32'(fp_in_ready), 32'h0100);
        tick();
        chk("fp_sel8", 32'(fp_out_sel), 32'd8);
        chk("rr_sel8", 32'(rr_out_sel), 32'd8);

        in_valid = 16'h0000;
        #1;
        chk("idle_rdy", 32'(rr_in_ready), 32'd0);
        tick();
        chk("idle_vld", 32'(rr_out_valid), 32'd0);
        chk("idle_sel", 32'(rr_out_sel), 32'd8);
        chk("idle_dat", 32'(rr_out_data), 32'h18);

        in_valid = 16'h0200;
        rr_beat("pulse9", 9, 8'h19);
        in_valid = 16'h0000;
        tick();
        chk("pulse_end_vld", 32'(rr_out_valid), 32'd0);
        chk("pulse_end_sel", 32'(rr_out_sel), 32'd9);

        in_valid = 16'h0008;
        rr_beat("mid_load", 3, 8'h13);
        out_ready = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 16'hFFFF;
        #1;
        chk("mid_rst_rdy", 32'(rr_in_ready), 32'd0);
        tick();
        chk("mid_rst_vld", 32'(rr_out_valid), 32'd0);
        chk("mid_rst_sel", 32'(rr_out_sel), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_16to1_rr.md
Name: mux_16to1_rr

Overview:
- 16-channel to 1-channel collector. It is the gather-side counterpart of the 1:16 one-hot demultiplexer.
- Each of 16 source channels presents data with a valid/ready handshake.
- The block arbitrates among active channels, then forwards one beat per cycle onto a single registered output.
- Each output beat carries the 4-bit index of its source channel, so downstream logic can route or decode it.

Parameters:
- DATA_W, 8: width of each channel's data word.
- PRIO_MODE, 0: arbitration mode. 0 = round-robin; 1 = fixed priority, lowest index wins.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- in_valid, input, 16: per-channel valid; bit i belongs to channel i.
- in_data, input, 16*DATA_W: channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready, output, 16: per-channel accept. At most one bit is high in any cycle.
- out_valid, output, 1: output beat valid.
- out_data, output, DATA_W: forwarded data word.
- out_sel, output, 4: source channel index of out_data.
- out_ready, input, 1: downstream accept.

Behaviour:
- Reset (rst_n low at a clk edge):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=0, so channel 0 has highest priority first.
  - Reset mid-transfer drops any held beat; no in_ready is issued during the reset cycle.
- load = !out_valid || out_ready. This is combinational and means the output register is free or draining this cycle.
- Grant g (combinational), computed only when load=1 and in_valid is nonzero:
  - PRIO_MODE=0: first set bit of in_valid, searching upward from index ptr and wrapping 15 -> 0.
  - PRIO_MODE=1: lowest set bit of in_valid; ptr is ignored.
- in_ready = one-hot(g) when load=1 and any in_valid is set; otherwise all zeros.
  - in_ready may depend on in_valid.
  - No in_ready bit is ever raised for a channel whose in_valid is low.
- Edge with load=1 and a grant:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - ptr <= (g+1) mod 16, so g=15 wraps ptr to 0.
- Edge with load=1 and no in_valid: out_valid <= 0; out_data, out_sel and ptr hold.
- Edge with load=0 (out_valid=1, out_ready=0): all outputs and ptr hold; in_ready=0.
- Latency: 1 cycle from input handshake to out_valid. Throughput: 1 beat/cycle when out_ready is held high.
- Fairness (PRIO_MODE=0): with all 16 channels continuously valid and out_ready=1, grants cycle 0,1,...,15,0 with no repeats inside a 16-beat window.
- Simultaneous events:
  - The output handshake and a new grant in the same cycle are allowed; the output register is overwritten with no bubble.
  - A channel granted in cycle t may be granted again in t+1 only if no other channel is valid (round-robin mode).
- Sources must hold in_valid and in_data stable until their in_ready handshake; the block does not check this.

Decomposition:
- Shared package demux_pkg:
  - N_CH=16, SEL_W=4.
  - typedef sel_t (logic [SEL_W-1:0]).
  - typedef onehot_t (logic [N_CH-1:0]).
  - The 1:16 demultiplexer uses the same package.
- One sub-module, rr_prio_encoder16: purely combinational.
  - Inputs: req[15:0], ptr, fixed_mode.
  - Outputs: gnt_onehot, gnt_idx, any.
  - The top module holds the ptr register, the output register and the handshake logic.

Test Plan:
- Reset: hold rst_n=0 with in_valid=16'hFFFF for 3 cycles -> out_valid=0, out_sel=0, in_ready=0 every cycle. Release -> first grant is channel 0, out_sel=0 one cycle later.
- Round-robin sweep: PRIO_MODE=0, in_valid=16'hFFFF, channel i data=i+8'h10, out_ready=1 -> out_sel sequence 0..15,0 on consecutive cycles; out_data=8'h10..8'h1F; in_ready is one-hot every cycle.
- Wrap and skip: in_valid=16'h8003, ptr=14 -> grants 15, 0, 1, 15; ptr wraps 15 -> 0 correctly.
- Backpressure: single grant of channel 5 (data 8'hA5), then out_ready=0 for 4 cycles -> out_valid=1, out_data=8'hA5, out_sel=5 stable; in_ready=0 throughout. out_ready=1 -> next grant on the same edge, no bubble.
- Fixed priority: PRIO_MODE=1, in_valid=16'h0110 held -> channel 4 is granted every cycle; channel 8 is never granted until channel 4 drops its valid.
- Idle and sparse: in_valid=0 -> out_valid falls after the current beat drains. A single pulse on channel 9 -> exactly one beat with out_sel=9.
